// File: rtl/game_sequencer_pkg.sv
// Shared game definitions: FSM state encoding, datapath ALU op codes and
// per-state decode helpers used by the sequencer and the datapath.
package game_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_CLEAR      = 4'd1,
    ST_WAIT_FRAME = 4'd2,
    ST_ERASE_B    = 4'd3,
    ST_ERASE_W    = 4'd4,
    ST_UPDATE     = 4'd5,
    ST_DRAW_B     = 4'd6,
    ST_DRAW_W     = 4'd7,
    ST_CHECK      = 4'd8,
    ST_OVER       = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    ALU_CLEAR  = 2'b00,
    ALU_ERASE  = 2'b01,
    ALU_UPDATE = 2'b10,
    ALU_DRAW   = 2'b11
  } alu_op_t;

  localparam logic OBJ_BIRD = 1'b0;
  localparam logic OBJ_WALL = 1'b1;

  // States that issue a datapath op and wait for draw_done.
  function automatic logic is_handshake(input state_t s);
    case (s)
      ST_CLEAR, ST_ERASE_B, ST_ERASE_W, ST_UPDATE, ST_DRAW_B, ST_DRAW_W: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic alu_op_t op_of(input state_t s);
    case (s)
      ST_ERASE_B, ST_ERASE_W: return ALU_ERASE;
      ST_UPDATE:              return ALU_UPDATE;
      ST_DRAW_B, ST_DRAW_W:   return ALU_DRAW;
      default:                return ALU_CLEAR;
    endcase
  endfunction

  function automatic logic obj_of(input state_t s);
    case (s)
      ST_ERASE_W, ST_DRAW_W: return OBJ_WALL;
      default:               return OBJ_BIRD;
    endcase
  endfunction

  function automatic logic plots(input state_t s);
    case (s)
      ST_CLEAR, ST_ERASE_B, ST_ERASE_W, ST_DRAW_B, ST_DRAW_W: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Two-digit BCD increment; max wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v == max) begin
      r = 8'h00;
    end else if (v[3:0] >= 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/game_sequencer_bcd.sv
// Two-digit BCD score register with synchronous clear and wrapping increment.
module bcd_score_counter
  import game_sequencer_pkg::*;
#(
  parameter logic [7:0] SCORE_MAX_BCD = 8'h99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  output logic [7:0] score
);

  // Score register; clear wins over increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      score <= 8'h00;
    end else if (clear) begin
      score <= 8'h00;
    end else if (inc) begin
      score <= bcd_inc(score, SCORE_MAX_BCD);
    end else begin
      score <= score;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game control FSM: sequences clear/erase/update/draw ops per video frame,
// tracks pending flaps, scores passed walls and flags timing errors.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int         DRAW_TIMEOUT  = 4095,
  parameter logic [7:0] SCORE_MAX_BCD = 8'h99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       flap,
  input  logic       draw_done,
  input  logic       collision,
  input  logic       wall_passed,
  output logic [1:0] alu_select,
  output logic       obj_sel,
  output logic       draw_start,
  output logic       plot_en,
  output logic       flap_apply,
  output logic [7:0] score,
  output logic       game_over,
  output logic       frame_overrun,
  output logic       draw_error
);

  localparam int            TW     = $clog2(DRAW_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(DRAW_TIMEOUT - 1);

  state_t        state, next_state;
  logic [TW-1:0] tcnt;
  logic          flap_pending;
  logic          op_done, timeout, entering, score_clear, score_inc;
  logic          tick_expected;

  assign entering      = (next_state != state);
  assign tick_expected = (state == ST_WAIT_FRAME) || (state == ST_IDLE) || (state == ST_OVER);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a timeout completes the op just like draw_done.
  always_comb begin
    next_state  = state;
    timeout     = 1'b0;
    op_done     = 1'b0;
    score_clear = 1'b0;
    score_inc   = 1'b0;
    if (is_handshake(state)) begin
      timeout = (tcnt == T_LAST) && !draw_done;
      op_done = draw_done || timeout;
    end else begin
      timeout = 1'b0;
      op_done = 1'b0;
    end
    case (state)
      ST_IDLE, ST_OVER: begin
        if (flap) begin
          next_state  = ST_CLEAR;
          score_clear = 1'b1;
        end else begin
          next_state = state;
        end
      end
      ST_CLEAR:      next_state = op_done    ? ST_WAIT_FRAME : state;
      ST_WAIT_FRAME: next_state = frame_tick ? ST_ERASE_B    : state;
      ST_ERASE_B:    next_state = op_done    ? ST_ERASE_W    : state;
      ST_ERASE_W:    next_state = op_done    ? ST_UPDATE     : state;
      ST_UPDATE:     next_state = op_done    ? ST_DRAW_B     : state;
      ST_DRAW_B:     next_state = op_done    ? ST_DRAW_W     : state;
      ST_DRAW_W:     next_state = op_done    ? ST_CHECK      : state;
      ST_CHECK: begin
        if (collision) begin
          next_state = ST_OVER;
        end else begin
          next_state = ST_WAIT_FRAME;
          score_inc  = wall_passed;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Registered outputs are decoded from the state being entered, so they
  // line up with the first cycle of that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      draw_start    <= 1'b0;
      alu_select    <= ALU_CLEAR;
      obj_sel       <= OBJ_BIRD;
      plot_en       <= 1'b0;
      game_over     <= 1'b0;
      flap_apply    <= 1'b0;
      flap_pending  <= 1'b0;
      tcnt          <= {TW{1'b0}};
      frame_overrun <= 1'b0;
      draw_error    <= 1'b0;
    end else begin
      draw_start <= entering && is_handshake(next_state);
      alu_select <= op_of(next_state);
      obj_sel    <= obj_of(next_state);
      plot_en    <= plots(next_state);
      game_over  <= (next_state == ST_OVER);
      flap_apply <= entering && (next_state == ST_UPDATE) && (flap_pending || flap);

      if (entering && (next_state == ST_UPDATE)) begin
        flap_pending <= 1'b0;
      end else if (score_clear) begin
        flap_pending <= 1'b0;
      end else if (flap && (state != ST_IDLE) && (state != ST_OVER)) begin
        flap_pending <= 1'b1;
      end else begin
        flap_pending <= flap_pending;
      end

      if (entering) begin
        tcnt <= {TW{1'b0}};
      end else if (is_handshake(state) && (tcnt != T_LAST)) begin
        tcnt <= tcnt + TW'(1);
      end else begin
        tcnt <= tcnt;
      end

      if (frame_tick && !tick_expected) begin
        frame_overrun <= 1'b1;
      end else begin
        frame_overrun <= frame_overrun;
      end

      if (timeout) begin
        draw_error <= 1'b1;
      end else begin
        draw_error <= draw_error;
      end
    end
  end

  bcd_score_counter #(
    .SCORE_MAX_BCD(SCORE_MAX_BCD)
  ) u_score (
    .clk   (clk),
    .reset (reset),
    .clear (score_clear),
    .inc   (score_inc),
    .score (score)
  );

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized bench for game_sequencer against a frame-level reference model.
module tb_game_sequencer;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       reset, frame_tick, flap, draw_done, collision, wall_passed;
  logic [1:0] alu_select;
  logic       obj_sel, draw_start, plot_en, flap_apply, game_over, frame_overrun, draw_error;
  logic [7:0] score;

  int checks = 0;
  int failures = 0;

  // Reference model state: decimal score and sticky flags.
  int m_score;
  bit m_pending, m_overrun, m_error;

  game_sequencer #(.DRAW_TIMEOUT(TO), .SCORE_MAX_BCD(8'h99)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .flap(flap),
    .draw_done(draw_done), .collision(collision), .wall_passed(wall_passed),
    .alu_select(alu_select), .obj_sel(obj_sel), .draw_start(draw_start),
    .plot_en(plot_en), .flap_apply(flap_apply), .score(score),
    .game_over(game_over), .frame_overrun(frame_overrun), .draw_error(draw_error)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int s);
    return 8'(((s / 10) * 16) + (s % 10));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({alu_select, obj_sel, draw_start, plot_en, flap_apply, game_over, frame_overrun, draw_error} !== 9'd0) begin
      failures++;
      $display("FAIL %s outputs got alu=%b obj=%b ds=%b pe=%b fa=%b go=%b fo=%b de=%b exp all 0",
               name, alu_select, obj_sel, draw_start, plot_en, flap_apply, game_over, frame_overrun, draw_error);
    end
    checks++;
    if (score !== 8'h00) begin
      failures++;
      $display("FAIL %s score got=%h exp=00", name, score);
    end
  endtask

  // One datapath op, starting in its first cycle. lat = cycles before draw_done;
  // withhold = never answer; flap_mode 0 none, 1 random, 2 every cycle.
  task automatic run_op(input string name, input logic [1:0] op, input logic obj, input logic plot,
                        input int lat, input int flap_mode, input bit withhold, input int tick_at);
    int n;
    n = withhold ? TO : lat + 1;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (draw_start !== (k == 0)) begin
        failures++;
        $display("FAIL %s draw_start k=%0d got=%b exp=%b", name, k, draw_start, (k == 0));
      end
      checks++;
      if (alu_select !== op || obj_sel !== obj) begin
        failures++;
        $display("FAIL %s op k=%0d got=%b/%b exp=%b/%b", name, k, alu_select, obj_sel, op, obj);
      end
      checks++;
      if (plot_en !== plot) begin
        failures++;
        $display("FAIL %s plot_en k=%0d got=%b exp=%b", name, k, plot_en, plot);
      end
      checks++;
      if (draw_error !== m_error || frame_overrun !== m_overrun || game_over !== 1'b0 || score !== to_bcd(m_score)) begin
        failures++;
        $display("FAIL %s status k=%0d got de=%b fo=%b go=%b sc=%h exp de=%b fo=%b go=0 sc=%h",
                 name, k, draw_error, frame_overrun, game_over, score, m_error, m_overrun, to_bcd(m_score));
      end
      checks++;
      if (k == 0 && op == 2'b10) begin
        if (flap_apply !== m_pending) begin
          failures++;
          $display("FAIL %s flap_apply got=%b exp=%b", name, flap_apply, m_pending);
        end
        m_pending = 1'b0;
      end else if (flap_apply !== 1'b0) begin
        failures++;
        $display("FAIL %s flap_apply k=%0d got=%b exp=0", name, k, flap_apply);
      end
      draw_done  = !withhold && (k == lat);
      flap       = (flap_mode == 2) || (flap_mode == 1 && $urandom_range(0, 3) == 0);
      frame_tick = (k == tick_at);
      if (flap) m_pending = 1'b1;
      if (frame_tick) m_overrun = 1'b1;
      tick();
    end
    draw_done  = 1'b0;
    flap       = 1'b0;
    frame_tick = 1'b0;
    if (withhold) m_error = 1'b1;
  endtask

  function automatic int pick(input int lat);
    return (lat < 0) ? int'($urandom_range(0, 4)) : lat;
  endfunction

  // Flap from IDLE/OVER, then the CLEAR op; ends in WAIT_FRAME.
  task automatic restart(input int lat);
    flap = 1'b1;
    m_pending = 1'b0;
    tick();
    flap = 1'b0;
    m_score = 0;
    run_op("clear", 2'b00, 1'b0, 1'b1, lat, 0, 1'b0, -1);
  endtask

  // One full frame from WAIT_FRAME through CHECK.
  task automatic run_frame(input string name, input int lat, input int fm_eb, input int fm,
                           input bit wall, input bit coll, input bit withhold_dw, input int tick_db);
    checks++;
    if (draw_start !== 1'b0 || plot_en !== 1'b0 || game_over !== 1'b0) begin
      failures++;
      $display("FAIL %s wait_frame got ds=%b pe=%b go=%b exp 0", name, draw_start, plot_en, game_over);
    end
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    run_op("erase_b", 2'b01, 1'b0, 1'b1, pick(lat), fm_eb, 1'b0, -1);
    run_op("erase_w", 2'b01, 1'b1, 1'b1, pick(lat), fm,    1'b0, -1);
    run_op("update",  2'b10, 1'b0, 1'b0, pick(lat), fm,    1'b0, -1);
    run_op("draw_b",  2'b11, 1'b0, 1'b1, (tick_db >= 0) ? 3 : pick(lat), fm, 1'b0, tick_db);
    run_op("draw_w",  2'b11, 1'b1, 1'b1, pick(lat), fm, withhold_dw, -1);
    checks++;
    if (plot_en !== 1'b0 || draw_start !== 1'b0 || draw_error !== m_error || frame_overrun !== m_overrun) begin
      failures++;
      $display("FAIL %s check_state got pe=%b ds=%b de=%b fo=%b exp pe=0 ds=0 de=%b fo=%b",
               name, plot_en, draw_start, draw_error, frame_overrun, m_error, m_overrun);
    end
    collision   = coll;
    wall_passed = wall;
    tick();
    collision   = 1'b0;
    wall_passed = 1'b0;
    if (!coll && wall) m_score = (m_score + 1) % 100;
    checks++;
    if (score !== to_bcd(m_score)) begin
      failures++;
      $display("FAIL %s score got=%h exp=%h", name, score, to_bcd(m_score));
    end
    checks++;
    if (game_over !== coll) begin
      failures++;
      $display("FAIL %s game_over got=%b exp=%b", name, game_over, coll);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_score = 0; m_pending = 1'b0; m_overrun = 1'b0; m_error = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    tick();
    check_reset_outputs("reset");
    for (int i = 0; i < 4; i++) begin
      frame_tick = 1'b1;
      draw_done  = 1'b1;
      tick();
      checks++;
      if (draw_start !== 1'b0 || plot_en !== 1'b0 || frame_overrun !== 1'b0) begin
        failures++;
        $display("FAIL idle_ignore got ds=%b pe=%b fo=%b exp 0", draw_start, plot_en, frame_overrun);
      end
    end
    frame_tick = 1'b0;
    draw_done  = 1'b0;
  endtask

  task automatic test_clear();
    restart(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (plot_en !== 1'b0 || draw_start !== 1'b0 || score !== 8'h00) begin
        failures++;
        $display("FAIL clear_wait got pe=%b ds=%b sc=%h exp 0/0/00", plot_en, draw_start, score);
      end
      draw_done = 1'b1;
      tick();
    end
    draw_done = 1'b0;
  endtask

  task automatic test_random();
    for (int f = 0; f < 20; f++) begin
      run_frame("random", -1, 1, 1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, -1);
    end
  endtask

  task automatic test_score_wrap();
    for (int f = 0; f < 100; f++) begin
      run_frame("wrap", 0, 0, 0, 1'b1, 1'b0, 1'b0, -1);
    end
  endtask

  task automatic test_collision();
    logic [7:0] held;
    run_frame("collide", 0, 0, 0, 1'b1, 1'b1, 1'b0, -1);
    held = to_bcd(m_score);
    for (int i = 0; i < 4; i++) begin
      frame_tick = 1'b1;
      draw_done  = 1'b1;
      tick();
      checks++;
      if (game_over !== 1'b1 || score !== held || draw_start !== 1'b0 || frame_overrun !== 1'b0) begin
        failures++;
        $display("FAIL over_hold got go=%b sc=%h ds=%b fo=%b exp 1/%h/0/0", game_over, score, draw_start, frame_overrun, held);
      end
    end
    frame_tick = 1'b0;
    draw_done  = 1'b0;
    restart(1);
  endtask

  task automatic test_timeout();
    run_frame("timeout", 1, 0, 0, 1'b0, 1'b0, 1'b1, -1);
    checks++;
    if (draw_error !== 1'b1) begin
      failures++;
      $display("FAIL timeout draw_error got=%b exp=1", draw_error);
    end
  endtask

  task automatic test_overrun();
    run_frame("overrun", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (draw_start !== 1'b0 || frame_overrun !== 1'b1) begin
        failures++;
        $display("FAIL overrun_no_frame got ds=%b fo=%b exp 0/1", draw_start, frame_overrun);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    run_op("erase_b", 2'b01, 1'b0, 1'b1, 0, 0, 1'b0, -1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_score = 0; m_pending = 1'b0; m_overrun = 1'b0; m_error = 1'b0;
    check_reset_outputs("reset_mid");
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    check_reset_outputs("reset_mid_idle");
  endtask

  initial begin
    reset = 1'b0; frame_tick = 1'b0; flap = 1'b0; draw_done = 1'b0;
    collision = 1'b0; wall_passed = 1'b0;
    m_score = 0; m_pending = 1'b0; m_overrun = 1'b0; m_error = 1'b0;
    test_reset();
    test_clear();
    run_frame("sequence", 0, 0, 0, 1'b0, 1'b0, 1'b0, -1);
    run_frame("flap3", 2, 2, 0, 1'b0, 1'b0, 1'b0, -1);
    run_frame("flap_none", 0, 0, 0, 1'b0, 1'b0, 1'b0, -1);
    test_random();
    test_score_wrap();
    test_collision();
    test_timeout();
    apply_reset();
    restart(0);
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter DRAW_TIMEOUT, default 4095: maximum cycles to wait for draw_done per draw phase.
REQ-002 SHALL have parameter SCORE_MAX_BCD, default 8'h99: last score value before wrapping to 8'h00.
REQ-003 SHALL have port clk  input  1  system clock (CLOCK_50 domain); the block uses one clock and a synchronous, active-high reset.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port frame_tick  input  1  one-cycle pulse per video frame.
REQ-006 SHALL have port flap  input  1  one-cycle pulse when the player presses the key (edge-detected upstream).
REQ-007 SHALL have port draw_done  input  1  one-cycle pulse from the datapath when the current op completes (finished_draw).
REQ-008 SHALL have port collision  input  1  level from the datapath, valid in CHECK.
REQ-009 SHALL have port wall_passed  input  1  level from the datapath, valid in CHECK.
REQ-010 SHALL have port alu_select  output  2  datapath op: 00 CLEAR, 01 ERASE, 10 UPDATE, 11 DRAW.
REQ-011 SHALL have port obj_sel  output  1  target object: 0 bird, 1 wall.
REQ-012 SHALL have port draw_start  output  1  one-cycle op start pulse.
REQ-013 SHALL have port plot_en  output  1  VGA write enable; high while a CLEAR, ERASE or DRAW op is outstanding.
REQ-014 SHALL have port flap_apply  output  1  one-cycle pulse in UPDATE when a flap is pending.
REQ-015 SHALL have port score  output  8  two-digit BCD score, wired to the HEX0/HEX1 decoders.
REQ-016 SHALL have port game_over  output  1  high in state OVER.
REQ-017 SHALL have ports frame_overrun and draw_error  output  1 each  sticky error flags.

Function
REQ-018 SHALL implement states IDLE, CLEAR, WAIT_FRAME, ERASE_B, ERASE_W, UPDATE, DRAW_B, DRAW_W, CHECK and OVER.
REQ-019 SHALL go IDLE->CLEAR on flap, and OVER->CLEAR on flap; entering CLEAR from OVER or IDLE SHALL zero the score.
REQ-020 SHALL sequence WAIT_FRAME --frame_tick--> ERASE_B -> ERASE_W -> UPDATE -> DRAW_B -> DRAW_W -> CHECK -> WAIT_FRAME or OVER.
REQ-021 SHALL pulse draw_start exactly once, in the first cycle of CLEAR, ERASE_*, UPDATE and DRAW_*, with alu_select and obj_sel stable for the whole state (obj_sel 0 in CLEAR).
REQ-022 SHALL leave each handshake state on the cycle after draw_done is sampled high; draw_done in the draw_start cycle SHALL be accepted.
REQ-023 SHALL ignore draw_done in IDLE, WAIT_FRAME, CHECK and OVER.
REQ-024 SHALL, if draw_done is absent for DRAW_TIMEOUT cycles after draw_start, set draw_error and advance as if draw_done had arrived.
REQ-025 SHALL latch flap into flap_pending in any state except IDLE and OVER, pulse flap_apply with draw_start in UPDATE, then clear flap_pending; multiple flaps within one frame SHALL yield a single flap_apply.
REQ-026 SHALL, in CHECK (one cycle), go to OVER when collision=1; otherwise increment score (BCD) when wall_passed=1 and return to WAIT_FRAME.
REQ-027 SHALL give collision priority over a simultaneous wall_passed: no increment in that case.
REQ-028 SHALL increment BCD with carry 09->10, and SHALL wrap SCORE_MAX_BCD->00.
REQ-029 SHALL set frame_overrun on a frame_tick outside WAIT_FRAME (IDLE/OVER excluded) and drop that tick.
REQ-030 SHALL deassert plot_en in UPDATE, CHECK, WAIT_FRAME, IDLE and OVER.
REQ-031 SHALL hold score unchanged in OVER.

Reset
REQ-032 SHALL, on reset, go to IDLE and clear score=00, flap_pending, the timeout counter, frame_overrun, draw_error, draw_start, plot_en, flap_apply and game_over.
REQ-033 SHALL, on reset, drive alu_select=00 and obj_sel=0.
REQ-034 SHALL take reset mid-operation on the next edge, abandoning any outstanding op without waiting for draw_done.

Structure
REQ-035 SHALL take the state encoding and the ALU op codes (CLEAR/ERASE/UPDATE/DRAW) from the shared game package, which the datapath also uses.
REQ-036 SHALL place BCD increment/wrap in one sub-module, bcd_score_counter.

Verification
REQ-037 SHALL cover: reset, flap, then draw_done 3 cycles after each start -> CLEAR then WAIT_FRAME; score=00; plot_en high only during CLEAR.
REQ-038 SHALL cover: frame_tick with draw_done immediate -> alu_select sequence 01,01,10,11,11 with obj_sel 0,1,0,0,1; 5 draw_start pulses.
REQ-039 SHALL cover: 3 flap pulses during ERASE_B -> exactly one flap_apply, in UPDATE.
REQ-040 SHALL cover: score=09 with wall_passed in CHECK -> 10; score=99 -> 00; collision and wall_passed together -> OVER with score unchanged.
REQ-041 SHALL cover: draw_done withheld in DRAW_W with DRAW_TIMEOUT=15 -> draw_error=1 after 15 cycles, then CHECK.
REQ-042 SHALL cover: frame_tick during DRAW_B -> frame_overrun=1 and no extra frame; reset asserted in ERASE_W -> IDLE with all outputs at reset values.
